meas_spi_regs: RTL and testbench
================================

Name: meas_spi_regs

Overview:
- Downstream stage of the square-wave frequency/duty measurement block. Holds its count results and exposes them to the STM32H743 host over a 4-wire SPI slave (mode 0).
- Provides a small control register that drives measurement enable and gate selection back to the measurement block.
- Everything runs in the sys_clk domain. SPI pins are oversampled; there is no SPI clock domain.

Parameters:
- DEVICE_ID, 8'h54, value returned at register address 0x00.
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on cs_n, sclk and mosi (legal values 2 or 3).
- CTRL_RST, 8'h01, reset value of the control register (meas_en = 1, gate_sel = 0).

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- meas_valid  in  1  one-cycle strobe: new result on the three count buses
- freq_cnt  in  32  measured-signal edge count over the gate
- ref_cnt  in  32  reference (200 MHz PLL) count over the gate
- high_cnt  in  32  reference count while the signal is high
- meas_en  out  1  control bit 0
- gate_sel  out  2  control bits 2:1 (gate time select)
- spi_cs_n  in  1  chip select, active low
- spi_sclk  in  1  SPI clock, max sys_clk/8
- spi_mosi  in  1  host-to-slave data
- spi_miso  out  1  slave-to-host data

Behaviour:
- Reset values: spi_miso = 0, meas_en/gate_sel = CTRL_RST bits, all shadow and snapshot registers = 0, status = 0, FSM = IDLE.
- Input synchronization:
  - SYNC_STAGES flip-flops on each SPI input.
  - Edges are detected on the synchronized sclk and cs_n.
  - Latency from pin to internal edge pulse is SYNC_STAGES+1 cycles.
- Shadow registers:
  - On meas_valid, the three counts are latched into shadows and status bit0 (new) is set.
  - meas_valid may arrive at any time, including during a frame.
- Snapshot:
  - On cs_n falling edge, all shadows plus status are copied into a snapshot.
  - Reads within a frame return only snapshot data, so a frame is always coherent.
  - A meas_valid in the same cycle as cs_n fall updates the shadows but not the snapshot.
- Register map (read): 0x00 DEVICE_ID; 0x01-0x04 freq_cnt MSB..LSB; 0x05-0x08 ref_cnt; 0x09-0x0C high_cnt; 0x0D status (bit0 new, bit1 overrun); 0x10 control; all other addresses return 8'h00.
- Frame format:
  - Byte 0 is the command: bit7 = 1 read, 0 write; bits 6:0 address.
  - Following bytes are data. The address auto-increments after each data byte and wraps 0x7F -> 0x00.
- FSM states: IDLE -> CMD on cs_n fall; CMD -> RD or WR after the 8th sclk rise; RD/WR stay until cs_n rise; any state -> IDLE on cs_n rise.
- Bit timing:
  - MOSI is sampled on the synchronized sclk rise, MSB first.
  - spi_miso changes only on the synchronized sclk fall.
  - During CMD, spi_miso = 0.
  - In RD, the data byte is loaded at the 8th rise, and its MSB is driven at the following fall.
- Partial bytes: fewer than 8 bits when cs_n rises are discarded. No write occurs and the address does not advance.
- Read clear: a frame that read any byte of 0x01-0x0C clears status.new at cs_n rise, unless a meas_valid arrived during the frame; in that case new stays 1.
- Overrun: status.overrun is set when meas_valid arrives while new = 1. It is cleared by a frame that reads 0x0D.
- Writes: only 0x10 is writable (bits 2:0); writes to other addresses are ignored. The control register updates one cycle after the 8th rise of the data byte.
- Reset mid-frame: the FSM returns to IDLE immediately, and the next cs_n fall is required before any transfer is decoded.
- With cs_n high, sclk and mosi activity is ignored.

Optional Feature:
- Macro MEAS_SPI_WR_EN.
- Defined: the write path is implemented as described above.
- Undefined:
  - Write commands are parsed, but their data is discarded.
  - meas_en/gate_sel are held constant at CTRL_RST.
  - Reads of 0x10 still return CTRL_RST[2:0].

Test Plan:
- Reset, then a read frame 0x80 + 1 dummy byte -> MISO returns 8'h54; meas_en = 1, gate_sel = 0.
- meas_valid with freq = 32'h0001_E240, ref = 32'h0BEB_C200, high = 32'h05F5_E100, then read 0x81 + 12 bytes -> 00 01 E2 40 0B EB C2 00 05 F5 E1 00; status read next returns 8'h00.
- Read frame from 0x81; a meas_valid with new values mid-frame -> all 12 bytes return the old values, status.new remains 1 after cs_n rise.
- Two meas_valid strobes with no read in between -> status = 8'h03; read 0x8D -> 8'h03; the following read 0x8D -> 8'h01.
- Write frame 0x10, 0x05 -> meas_en = 1, gate_sel = 2'b10 (with MEAS_SPI_WR_EN); without the macro -> outputs stay at 1/0 and read 0x90 returns 8'h01.
- Write frame 0x10 with cs_n raised after 5 data bits -> control unchanged; sys_rst_n pulsed mid-read -> spi_miso = 0, next frame 0x80 returns 8'h54.

Source files
------------

// File: rtl/meas_spi_regs_if.sv
// 4-wire SPI bus between the host (master) and the measurement register slave.
interface meas_spi_regs_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/meas_spi_regs.sv
// Measurement result registers behind an oversampled SPI mode-0 slave.
// Counts are shadowed on meas_valid and snapshotted at frame start so every
// read frame is coherent. Optional macro MEAS_SPI_WR_EN enables writes to the
// control register at 0x10; without it the control outputs stay at CTRL_RST.
module meas_spi_regs #(
  parameter logic [7:0]  DEVICE_ID   = 8'h54,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CTRL_RST    = 8'h01
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           meas_valid,
  input  logic [31:0]    freq_cnt,
  input  logic [31:0]    ref_cnt,
  input  logic [31:0]    high_cnt,
  output logic           meas_en,
  output logic [1:0]     gate_sel,
  meas_spi_regs_if.slave spi
);

  typedef enum logic [1:0] {StIdle, StCmd, StRd, StWr} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic cs_prev_q, sclk_prev_q;
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_q, addr_q, rd_addr;
  logic [7:0]  tx_q, rx_byte, rd_data;
  logic        miso_q, rd_cnt_q, rd_stat_q, valid_seen_q;
  logic        frame_start, frame_end, byte_done;
  logic [31:0] freq_sh_q, ref_sh_q, high_sh_q, freq_sn_q, ref_sn_q, high_sn_q;
  logic        new_q, ovr_q;
  logic [1:0]  status_sn_q;
  logic [2:0]  ctrl;

  // Pin synchronizers; chains reset low so a frame in progress at reset is never decoded
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // FSM next state and frame/byte strobes; cs_n rise takes priority over sclk
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    byte_done   = 1'b0;
    rx_byte     = {rx_q, mosi_s};
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d     = StCmd;
          frame_start = 1'b1;
        end
      end
      StCmd, StRd, StWr: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frame_end = 1'b1;
        end else if (sclk_rise && bit_cnt_q == 3'd7) begin
          byte_done = 1'b1;
          if (state_q == StCmd) state_d = rx_byte[7] ? StRd : StWr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte after the one in flight: command address, or auto-incremented (wraps at 0x7F)
  assign rd_addr = (state_q == StCmd) ? rx_byte[6:0] : addr_q + 7'd1;

  // Read mux; in-frame data comes only from the snapshot
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'h00:   rd_data = DEVICE_ID;
      7'h01:   rd_data = freq_sn_q[31:24];
      7'h02:   rd_data = freq_sn_q[23:16];
      7'h03:   rd_data = freq_sn_q[15:8];
      7'h04:   rd_data = freq_sn_q[7:0];
      7'h05:   rd_data = ref_sn_q[31:24];
      7'h06:   rd_data = ref_sn_q[23:16];
      7'h07:   rd_data = ref_sn_q[15:8];
      7'h08:   rd_data = ref_sn_q[7:0];
      7'h09:   rd_data = high_sn_q[31:24];
      7'h0A:   rd_data = high_sn_q[23:16];
      7'h0B:   rd_data = high_sn_q[15:8];
      7'h0C:   rd_data = high_sn_q[7:0];
      7'h0D:   rd_data = {6'd0, status_sn_q};
      7'h10:   rd_data = {5'd0, ctrl};
      default: rd_data = 8'h00;
    endcase
  end

  // Shift logic: sample MOSI on rise, drive MISO on fall, track which registers were read
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      addr_q    <= 7'd0;
      tx_q      <= 8'd0;
      miso_q    <= 1'b0;
      rd_cnt_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else if (frame_start) begin
      bit_cnt_q <= 3'd0;
      miso_q    <= 1'b0;
      rd_cnt_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else if (frame_end) begin
      miso_q <= 1'b0;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        rx_q      <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        addr_q <= rd_addr;
        tx_q   <= rd_data;
        if (state_q == StRd) begin
          if (addr_q >= 7'h01 && addr_q <= 7'h0C) rd_cnt_q <= 1'b1;
          if (addr_q == 7'h0D) rd_stat_q <= 1'b1;
        end
      end
      if (sclk_fall) begin
        if (state_q == StRd) begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  // Shadows follow meas_valid; snapshot captures pre-strobe shadows at frame start
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      freq_sh_q   <= '0;
      ref_sh_q    <= '0;
      high_sh_q   <= '0;
      freq_sn_q   <= '0;
      ref_sn_q    <= '0;
      high_sn_q   <= '0;
      status_sn_q <= '0;
    end else begin
      if (meas_valid) begin
        freq_sh_q <= freq_cnt;
        ref_sh_q  <= ref_cnt;
        high_sh_q <= high_cnt;
      end
      if (frame_start) begin
        freq_sn_q   <= freq_sh_q;
        ref_sn_q    <= ref_sh_q;
        high_sn_q   <= high_sh_q;
        status_sn_q <= {ovr_q, new_q};
      end
    end
  end

  // Status flags; a strobe always wins over the end-of-frame clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      new_q        <= 1'b0;
      ovr_q        <= 1'b0;
      valid_seen_q <= 1'b0;
    end else begin
      if (frame_start)                            valid_seen_q <= meas_valid;
      else if (meas_valid && state_q != StIdle)   valid_seen_q <= 1'b1;
      if (frame_end && rd_cnt_q && !valid_seen_q) new_q <= 1'b0;
      if (frame_end && rd_stat_q)                 ovr_q <= 1'b0;
      if (meas_valid) begin
        new_q <= 1'b1;
        if (new_q) ovr_q <= 1'b1;
      end
    end
  end

`ifdef MEAS_SPI_WR_EN
  logic [2:0] ctrl_q;

  // Control register, written by a completed data byte addressed to 0x10
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ctrl_q <= CTRL_RST[2:0];
    else if (byte_done && state_q == StWr && addr_q == 7'h10) ctrl_q <= rx_byte[2:0];
  end

  assign ctrl = ctrl_q;
`else
  assign ctrl = CTRL_RST[2:0];
`endif

  assign meas_en      = ctrl[0];
  assign gate_sel     = ctrl[2:1];
  assign spi.spi_miso = miso_q;

endmodule

// File: tb/tb_meas_spi_regs.sv
// Bench for meas_spi_regs: SPI host driver plus a byte-level register model.
`timescale 1ns/1ps
module tb_meas_spi_regs;

  localparam logic [7:0] DEV_ID = 8'h54;
  localparam logic [7:0] CTRL_R = 8'h01;
`ifdef MEAS_SPI_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        meas_valid = 1'b0;
  logic [31:0] freq_cnt = '0, ref_cnt = '0, high_cnt = '0;
  logic        meas_en;
  logic [1:0]  gate_sel;

  meas_spi_regs_if spi_if ();

  meas_spi_regs dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .meas_valid (meas_valid),
    .freq_cnt   (freq_cnt),
    .ref_cnt    (ref_cnt),
    .high_cnt   (high_cnt),
    .meas_en    (meas_en),
    .gate_sel   (gate_sel),
    .spi        (spi_if)
  );

  always #10 sys_clk = ~sys_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: register contents as the host sees them
  logic [31:0] m_freq, m_ref, m_high;
  bit          m_new, m_ovr;
  logic [2:0]  m_ctrl;

  logic [7:0] tb_tx [16];
  logic [7:0] tb_rx [16];
  logic [7:0] exp_b [16];
  logic [7:0] cmd_rx;

  task automatic model_reset();
    m_freq = '0; m_ref = '0; m_high = '0;
    m_new = 1'b0; m_ovr = 1'b0;
    m_ctrl = CTRL_R[2:0];
  endtask

  function automatic logic [7:0] model_reg(input int a);
    logic [95:0] cat;
    cat = {m_freq, m_ref, m_high};
    if (a == 0) return DEV_ID;
    if (a >= 1 && a <= 12) return cat[95 - 8 * (a - 1) -: 8];
    if (a == 13) return {6'd0, m_ovr, m_new};
    if (a == 16) return {5'd0, m_ctrl};
    return 8'h00;
  endfunction

  // Completed read of n bytes starting at start; valid_seen = a strobe hit the frame
  task automatic model_read_done(input int start, input int n, input bit valid_seen);
    bit cnt_rd = 0, st_rd = 0;
    for (int i = 0; i < n; i++) begin
      int a = (start + i) % 128;
      if (a >= 1 && a <= 12) cnt_rd = 1;
      if (a == 13) st_rd = 1;
    end
    if (cnt_rd && !valid_seen) m_new = 1'b0;
    if (st_rd) m_ovr = 1'b0;
  endtask

  task automatic model_write(input int start, input int n);
    for (int i = 0; i < n; i++)
      if ((start + i) % 128 == 16 && WR_EN) m_ctrl = tb_tx[i][2:0];
  endtask

  function automatic void expect_read(input int start, input int n);
    for (int i = 0; i < n; i++) exp_b[i] = model_reg((start + i) % 128);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic meas_strobe(input logic [31:0] f, input logic [31:0] r, input logic [31:0] h);
    @(negedge sys_clk);
    meas_valid = 1'b1; freq_cnt = f; ref_cnt = r; high_cnt = h;
    @(negedge sys_clk);
    meas_valid = 1'b0;
    if (m_new) m_ovr = 1'b1;
    m_new = 1'b1;
    m_freq = f; m_ref = r; m_high = h;
  endtask

  task automatic xfer_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_mosi = b[7-i];
      wait_clk(6);
      r[7-i] = spi_if.spi_miso;
      spi_if.spi_sclk = 1'b1;
      wait_clk(6);
      spi_if.spi_sclk = 1'b0;
    end
  endtask

  // Frame: command + nbytes of tb_tx; last byte has last_bits bits; optional mid-frame strobe
  task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int last_bits,
                           input int strobe_after, input bit keep_cs);
    logic [7:0] r;
    @(negedge sys_clk);
    spi_if.spi_cs_n = 1'b0;
    wait_clk(4);
    xfer_byte(cmd, 8, r);
    cmd_rx = r;
    for (int i = 0; i < nbytes; i++) begin
      if (i == strobe_after) meas_strobe($urandom, $urandom, $urandom);
      xfer_byte(tb_tx[i], (i == nbytes - 1) ? last_bits : 8, r);
      tb_rx[i] = r;
    end
    wait_clk(6);
    if (!keep_cs) begin
      spi_if.spi_cs_n = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic test_reset();
    wait_clk(2);
    tests_run++;
    if (meas_en !== CTRL_R[0]) begin
      tests_failed++; $display("FAIL reset_meas_en: got %b want %b", meas_en, CTRL_R[0]);
    end
    tests_run++;
    if (gate_sel !== CTRL_R[2:1]) begin
      tests_failed++; $display("FAIL reset_gate_sel: got %b want %b", gate_sel, CTRL_R[2:1]);
    end
    tests_run++;
    if (spi_if.spi_miso !== 1'b0) begin
      tests_failed++; $display("FAIL reset_miso: got %b want 0", spi_if.spi_miso);
    end
  endtask

  task automatic test_device_id();
    tb_tx[0] = 8'h00;
    spi_frame(8'h80, 1, 8, -1, 1'b0);
    tests_run++;
    if (cmd_rx !== 8'h00) begin
      tests_failed++; $display("FAIL cmd_phase_miso: got %h want 00", cmd_rx);
    end
    tests_run++;
    if (tb_rx[0] !== DEV_ID) begin
      tests_failed++; $display("FAIL device_id: got %h want %h", tb_rx[0], DEV_ID);
    end
  endtask

  task automatic test_known_vector();
    meas_strobe(32'h0001_E240, 32'h0BEB_C200, 32'h05F5_E100);
    expect_read(1, 12);
    for (int i = 0; i < 12; i++) tb_tx[i] = 8'h00;
    spi_frame(8'h81, 12, 8, -1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (tb_rx[i] !== exp_b[i]) begin
        tests_failed++; $display("FAIL known_byte%0d: got %h want %h", i, tb_rx[i], exp_b[i]);
      end
    end
    model_read_done(1, 12, 1'b0);
    expect_read(13, 1);
    spi_frame(8'h8D, 1, 8, -1, 1'b0);
    tests_run++;
    if (tb_rx[0] !== exp_b[0]) begin
      tests_failed++; $display("FAIL known_status: got %h want %h", tb_rx[0], exp_b[0]);
    end
    model_read_done(13, 1, 1'b0);
  endtask

  task automatic test_random_reads();
    for (int it = 0; it < 16; it++) begin
      int start, n;
      if ($urandom_range(0, 1) == 1) meas_strobe($urandom, $urandom, $urandom);
      start = (it % 4 == 3) ? $urandom_range(124, 127) : $urandom_range(0, 18);
      n = $urandom_range(1, 6);
      expect_read(start, n);
      for (int i = 0; i < n; i++) tb_tx[i] = 8'($urandom);
      spi_frame({1'b1, 7'(start)}, n, 8, -1, 1'b0);
      for (int i = 0; i < n; i++) begin
        tests_run++;
        if (tb_rx[i] !== exp_b[i]) begin
          tests_failed++;
          $display("FAIL rand_read addr %h: got %h want %h", (start + i) % 128, tb_rx[i], exp_b[i]);
        end
      end
      model_read_done(start, n, 1'b0);
    end
  endtask

  task automatic test_mid_frame();
    expect_read(1, 12);
    for (int i = 0; i < 12; i++) tb_tx[i] = 8'h00;
    spi_frame(8'h81, 12, 8, 5, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (tb_rx[i] !== exp_b[i]) begin
        tests_failed++; $display("FAIL coherent_byte%0d: got %h want %h", i, tb_rx[i], exp_b[i]);
      end
    end
    model_read_done(1, 12, 1'b1);
    expect_read(13, 1);
    spi_frame(8'h8D, 1, 8, -1, 1'b0);
    tests_run++;
    if (tb_rx[0] !== exp_b[0]) begin
      tests_failed++; $display("FAIL mid_frame_status: got %h want %h", tb_rx[0], exp_b[0]);
    end
    model_read_done(13, 1, 1'b0);
  endtask

  task automatic test_overrun();
    meas_strobe($urandom, $urandom, $urandom);
    meas_strobe($urandom, $urandom, $urandom);
    for (int k = 0; k < 2; k++) begin
      expect_read(13, 1);
      spi_frame(8'h8D, 1, 8, -1, 1'b0);
      tests_run++;
      if (tb_rx[0] !== exp_b[0]) begin
        tests_failed++; $display("FAIL overrun_read%0d: got %h want %h", k, tb_rx[0], exp_b[0]);
      end
      model_read_done(13, 1, 1'b0);
    end
  endtask

  task automatic test_write();
    tb_tx[0] = 8'h05;
    spi_frame(8'h10, 1, 8, -1, 1'b0);
    model_write(16, 1);
    tests_run++;
    if ({gate_sel, meas_en} !== m_ctrl) begin
      tests_failed++; $display("FAIL write_ctrl: got %b want %b", {gate_sel, meas_en}, m_ctrl);
    end
    for (int it = 0; it < 4; it++) begin
      int start = (it % 2 == 0) ? 14 : 17;
      for (int i = 0; i < 3; i++) tb_tx[i] = 8'($urandom);
      spi_frame(7'(start), 3, 8, -1, 1'b0);
      model_write(start, 3);
      tests_run++;
      if ({gate_sel, meas_en} !== m_ctrl) begin
        tests_failed++;
        $display("FAIL write_incr%0d: got %b want %b", it, {gate_sel, meas_en}, m_ctrl);
      end
    end
    expect_read(16, 1);
    spi_frame(8'h90, 1, 8, -1, 1'b0);
    tests_run++;
    if (tb_rx[0] !== exp_b[0]) begin
      tests_failed++; $display("FAIL read_ctrl: got %h want %h", tb_rx[0], exp_b[0]);
    end
  endtask

  task automatic test_partial();
    tb_tx[0] = {5'b11111, ~m_ctrl};
    spi_frame(8'h10, 1, 5, -1, 1'b0);
    tests_run++;
    if ({gate_sel, meas_en} !== m_ctrl) begin
      tests_failed++; $display("FAIL partial_write: got %b want %b", {gate_sel, meas_en}, m_ctrl);
    end
  endtask

  task automatic test_reset_mid_frame();
    meas_strobe($urandom, $urandom, $urandom);
    tb_tx[0] = 8'h00;
    spi_frame(8'h80, 1, 1, -1, 1'b1);
    tests_run++;
    if (spi_if.spi_miso !== DEV_ID[6]) begin
      tests_failed++; $display("FAIL pre_reset_miso: got %b want %b", spi_if.spi_miso, DEV_ID[6]);
    end
    sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if (spi_if.spi_miso !== 1'b0 || {gate_sel, meas_en} !== CTRL_R[2:0]) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: got miso %b ctrl %b want 0 %b", spi_if.spi_miso,
               {gate_sel, meas_en}, CTRL_R[2:0]);
    end
    wait_clk(3);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      spi_if.spi_mosi = 1'($urandom);
      wait_clk(6); spi_if.spi_sclk = 1'b1;
      wait_clk(6); spi_if.spi_sclk = 1'b0;
    end
    wait_clk(6);
    spi_if.spi_cs_n = 1'b1;
    wait_clk(10);
    expect_read(0, 5);
    for (int i = 0; i < 5; i++) tb_tx[i] = 8'h00;
    spi_frame(8'h80, 5, 8, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (tb_rx[i] !== exp_b[i]) begin
        tests_failed++; $display("FAIL post_reset_byte%0d: got %h want %h", i, tb_rx[i], exp_b[i]);
      end
    end
    model_read_done(0, 5, 1'b0);
  endtask

  initial begin
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_mosi = 1'b0;
    model_reset();
    wait_clk(5);
    sys_rst_n = 1'b1;
    test_reset();
    test_device_id();
    test_known_vector();
    test_random_reads();
    test_mid_frame();
    test_overrun();
    test_write();
    test_partial();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
